// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning block.
// Channel FSM encoding, button indices and 100 MHz timing defaults.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  localparam int DEF_N_BTN               = 5;
  localparam int DEF_DEBOUNCE_CYCLES     = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES = 40_000_000;  // 400 ms
  localparam int DEF_REPEAT_RATE_CYCLES  = 10_000_000;  // 100 ms
  localparam int DEF_CNT_W               = 26;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic act;
  } btn_evt_t;

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce FSM and hold-to-repeat counter.
// All event outputs are registered.
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     raw,
  input  logic     repeat_en,
  output btn_evt_t evt
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic             sync1, sync;
  btn_state_e       state, state_nx;
  logic [CNT_W-1:0] db_cnt, db_nx;
  logic [CNT_W-1:0] rep_cnt, rep_nx, rep_last;
  logic             first_rep, first_nx;
  btn_evt_t         evt_nx;

  assign rep_last = first_rep ? DLY_LAST : RATE_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync      <= 1'b0;
      state     <= IDLE;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      first_rep <= 1'b0;
      evt       <= '0;
    end else begin
      sync1     <= raw;
      sync      <= sync1;
      state     <= state_nx;
      db_cnt    <= db_nx;
      rep_cnt   <= rep_nx;
      first_rep <= first_nx;
      evt       <= evt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    db_nx    = db_cnt;
    rep_nx   = rep_cnt;
    first_nx = first_rep;
    evt_nx   = '0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nx = DB_PRESS;
          db_nx    = '0;
        end
      end
      DB_PRESS: begin
        if (!sync) begin
          state_nx = IDLE;
          db_nx    = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx     = HELD;
          db_nx        = '0;
          rep_nx       = '0;
          first_nx     = 1'b1;
          evt_nx.press = 1'b1;
          evt_nx.act   = 1'b1;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      HELD: begin
        // Disabling repeat parks the interval at 0 so re-enable restarts it.
        if (!sync) begin
          state_nx = DB_RELEASE;
          db_nx    = '0;
        end else if (!repeat_en) begin
          rep_nx = '0;
        end else if (rep_cnt == rep_last) begin
          evt_nx.act = 1'b1;
          rep_nx     = '0;
          first_nx   = 1'b0;
        end else begin
          rep_nx = rep_cnt + 1'b1;
        end
      end
      DB_RELEASE: begin
        // A bounce back to HELD keeps rep_cnt so the repeat cadence survives.
        if (sync) begin
          state_nx = HELD;
          db_nx    = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx   = IDLE;
          db_nx      = '0;
          evt_nx.rel = 1'b1;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    evt_nx.level = (state_nx == HELD) || (state_nx == DB_RELEASE);
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons: one independent button_channel per bit.
// btn_act feeds the movement logic in place of the raw buttons.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN               = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_evt_t evt;

    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .CNT_W              (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[i]),
      .repeat_en(repeat_en[i]),
      .evt      (evt)
    );

    assign btn_level[i]   = evt.level;
    assign btn_press[i]   = evt.press;
    assign btn_release[i] = evt.rel;
    assign btn_act[i]     = evt.act;
  end

endmodule
